rr_onehot_arbiter: RTL and testbench

//  Round-robin arbiter: grants one of N requesters, holds the grant until the owner signals done.

---
 rtl/arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 36 +++
 rtl/rr_onehot_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ============================================================================
// arb_pkg : shared state encoding, hold-counter width and one-hot index helper
// Rev 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int HOLD_W = 8;

  // Index of the set bit in a one-hot vector (up to 16 requesters).
  function automatic logic [3:0] onehot_idx(input logic [15:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin select, lowest set bit at or above ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic             any
);

  logic [N-1:0] rot;
  logic [N-1:0] sel;

  // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot  = '0;
    pick = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req[(j + int'(ptr)) % N];
    end
    sel = rot & (~rot + 1'b1);
    for (int j = 0; j < N; j++) begin
      pick[(j + int'(ptr)) % N] = sel[j];
    end
    any = |req;
  end

endmodule

`default_nettype wire

// File: rtl/rr_onehot_arbiter.sv
// ============================================================================
// rr_onehot_arbiter : round-robin arbiter with registered one-hot grant held
// until done. Optional forced release enabled by macro ARB_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic         grant_vld,
  output logic         busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic         timeout
`endif
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   pick_ptr;
  logic [N-1:0]       pick;
  logic               any;
  logic               limit;

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               timeout_q, timeout_d;

  assign limit   = (hold_q == HOLD_W'(MAX_HOLD));
  assign timeout = timeout_q;
`else
  logic [31:0]        unused_max_hold;

  assign limit           = 1'b0;
  assign unused_max_hold = MAX_HOLD;
`endif

  assign owner    = PTR_W'(onehot_idx(16'(grant_q)));
  assign next_ptr = (owner == PTR_W'(N - 1)) ? '0 : owner + 1'b1;
  // On release the search already starts after the outgoing owner.
  assign pick_ptr = (state_q == ST_GRANT) ? next_ptr : ptr_q;

  rr_pick #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d = ST_GRANT;
          grant_d = pick;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (done || limit) begin
          ptr_d = next_ptr;
`ifdef ARB_TIMEOUT_EN
          timeout_d = limit & ~done;
          hold_d    = '0;
`endif
          if (any) begin
            grant_d = pick;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_d = hold_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign grant_vld = (state_q == ST_GRANT);
  assign busy      = grant_vld;

endmodule

`default_nettype wire

// File: tb/tb_rr_onehot_arbiter.sv
// ============================================================================
// tb_rr_onehot_arbiter : scoreboard bench with a behavioural round-robin model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rr_onehot_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 15;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic         grant_vld;
  logic         busy;
`ifdef ARB_TIMEOUT_EN
  logic         timeout;
`endif

  rr_onehot_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_vld (grant_vld),
    .busy      (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    logic         v;
    logic         to;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model: owner index (-1 = none), pointer, cycles held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  function automatic int first_from(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    exp_t         e;
    logic [N-1:0] one;
    one = 1;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        if (req != 0) begin
          m_owner = first_from(m_ptr, req);
          m_hold  = 0;
        end
      end else if (done || (TO_EN && m_hold == MAX_HOLD)) begin
        m_to  = !done;
        m_ptr = (m_owner + 1) % N;
        if (req != 0) begin
          m_owner = first_from(m_ptr, req);
          m_hold  = 0;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_hold++;
      end
    end
    e.g  = (m_owner < 0) ? '0 : (one << m_owner);
    e.v  = (m_owner >= 0);
    e.to = m_to;
    exp_q.push_back(e);
  endtask

  // Drive inputs for one cycle, then let the model see the same edge.
  task automatic tick(input logic r, input logic [N-1:0] q, input logic d);
    rst  = r;
    req  = q;
    done = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant", 32'(grant), 32'(e.g));
        check("grant_vld", 32'(grant_vld), 32'(e.v));
        check("busy", 32'(busy), 32'(e.v));
        check("onehot0", 32'($onehot0(grant)), 32'd1);
`ifdef ARB_TIMEOUT_EN
        check("timeout", 32'(timeout), 32'(e.to));
`endif
      end
    end
  end

  initial begin
    int k;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;

    // Reset held with all requests active, then first grant to index 0.
    tick(1'b1, 4'b1111, 1'b0);
    tick(1'b1, 4'b1111, 1'b0);
    tick(1'b0, 4'b1111, 1'b0);

    // Rotation with done every third cycle.
    for (int i = 0; i < 15; i++) tick(1'b0, 4'b1111, (i % 3 == 2));
    tick(1'b0, 4'b0000, 1'b1);

    // Skip and wrap.
    tick(1'b1, 4'b0000, 1'b0);
    tick(1'b0, 4'b0100, 1'b0);
    tick(1'b0, 4'b0101, 1'b0);
    tick(1'b0, 4'b0101, 1'b1);
    tick(1'b0, 4'b0101, 1'b0);
    tick(1'b0, 4'b0101, 1'b1);
    tick(1'b0, 4'b0000, 1'b1);
    tick(1'b0, 4'b0000, 1'b1);

    // Grant frozen while the owner drops its request.
    tick(1'b1, 4'b0000, 1'b0);
    tick(1'b0, 4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 4'b1000, 1'b0);
    tick(1'b0, 4'b1000, 1'b1);
    tick(1'b0, 4'b0000, 1'b1);

    // Reset during GRANT restarts arbitration from index 0.
    tick(1'b0, 4'b1111, 1'b0);
    tick(1'b0, 4'b1111, 1'b1);
    tick(1'b1, 4'b1111, 1'b0);
    tick(1'b0, 4'b1111, 1'b0);
    tick(1'b0, 4'b1111, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Forced release, then done coinciding with the limit.
    tick(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 4'b0011, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 4'b0011, (m_owner >= 0 && m_hold == MAX_HOLD));
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 59) == 0),
           (($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom)),
           ($urandom_range(0, 2) == 0));
    end
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 200; i++) tick(1'b0, 4'($urandom), ($urandom_range(0, 24) == 0));
`endif

    k = 0;
    while (exp_q.size() != 0 && k < 5) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
